// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between instruction fetch and the data path.
// Optional WAIT-state watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_write,
    output logic              mem_enable,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_busy,
    output logic              owner,
    output logic              arb_busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_rdata, r_dm_rdata;
    logic                r_rw, r_owner, r_last_grant;
    logic                r_if_ack, r_dm_ack;
    logic                w_if_req, w_dm_req, w_grant, w_grant_dm;
    logic                w_done, w_timeout;

    // A port being acked this cycle is masked so a held request is not re-issued.
    assign w_if_req   = if_req & ~r_if_ack;
    assign w_dm_req   = dm_req & ~r_dm_ack;
    assign w_grant    = (r_state == S_IDLE) & (w_if_req | w_dm_req);
    assign w_grant_dm = w_dm_req & (~w_if_req | ~r_last_grant);
    assign w_done     = (r_state == S_WAIT) & (~mem_busy | w_timeout);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;

    assign w_timeout = (r_state == S_WAIT) & mem_busy & (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout)
                r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_ack <= w_done & ~r_owner;
            r_dm_ack <= w_done &  r_owner;
            if (w_grant) begin
                r_owner      <= w_grant_dm;
                r_last_grant <= w_grant_dm;
                if (w_grant_dm) begin
                    r_addr  <= dm_addr;
                    r_wdata <= dm_wdata;
                    r_rw    <= ~dm_we;
                end else begin
                    r_addr  <= if_addr;
                    r_rw    <= 1'b1;
                end
            end
            // Stores leave rdata alone; a watchdog abort always zeroes it.
            if (w_done && !r_owner)
                r_if_rdata <= w_timeout ? '0 : mem_data_out;
            if (w_done && r_owner && (r_rw || w_timeout))
                r_dm_rdata <= w_timeout ? '0 : mem_data_out;
        end
    end

    assign if_ack         = r_if_ack;
    assign dm_ack         = r_dm_ack;
    assign if_rdata       = r_if_rdata;
    assign dm_rdata       = r_dm_rdata;
    assign mem_address    = r_addr;
    assign mem_data_in    = r_wdata;
    assign mem_read_write = r_rw;
    assign mem_enable     = (r_state == S_ISSUE) | (r_state == S_WAIT);
    assign owner          = r_owner;
    assign arb_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for latency, grant order, reset abort and timeout.
module tb_mem_port_arbiter;

    localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        if_req = 0, dm_req = 0, dm_we = 0, mem_busy = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_data_out = 0;
    logic        if_ack, dm_ack, mem_read_write, mem_enable, owner, arb_busy, timeout_err;
    logic [31:0] if_rdata, dm_rdata, mem_address, mem_data_in;

    int n_tests = 0, n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_enable(mem_enable),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy),
        .owner(owner), .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a transfer is in flight from grant until the first
    // WAIT edge (age >= 1) that sees busy low or hits the watchdog limit.
    logic        m_fly, m_owner, m_last, m_rw, m_if_ack, m_dm_ack, m_terr, m_abort;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
    int          m_age;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_fly <= 0; m_owner <= 0; m_last <= 0; m_rw <= 0; m_if_ack <= 0;
            m_dm_ack <= 0; m_terr <= 0; m_addr <= 0; m_wdata <= 0;
            m_ifr <= 0; m_dmr <= 0; m_age <= 0;
        end else begin
            m_if_ack <= 0;
            m_dm_ack <= 0;
            if (!m_fly) begin
                if ((if_req && !m_if_ack) || (dm_req && !m_dm_ack)) begin
                    if (dm_req && !m_dm_ack && (!(if_req && !m_if_ack) || !m_last)) begin
                        m_owner <= 1; m_last <= 1; m_addr <= dm_addr;
                        m_wdata <= dm_wdata; m_rw <= !dm_we;
                    end else begin
                        m_owner <= 0; m_last <= 0; m_addr <= if_addr; m_rw <= 1;
                    end
                    m_fly <= 1;
                    m_age <= 0;
                end
            end else begin
                m_age <= m_age + 1;
                if (m_age >= 1 && (!mem_busy || (TO_EN && m_age == TO))) begin
                    m_abort = mem_busy;
                    m_fly  <= 0;
                    if (m_abort) m_terr <= 1;
                    if (m_owner) begin
                        m_dm_ack <= 1;
                        if (m_abort) m_dmr <= 0;
                        else if (m_rw) m_dmr <= mem_data_out;
                    end else begin
                        m_if_ack <= 1;
                        m_ifr <= m_abort ? 32'h0 : mem_data_out;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("if_ack", if_ack, m_if_ack);
        chk("dm_ack", dm_ack, m_dm_ack);
        chk("if_rdata", if_rdata, m_ifr);
        chk("dm_rdata", dm_rdata, m_dmr);
        chk("mem_address", mem_address, m_addr);
        chk("mem_read_write", mem_read_write, m_rw);
        chk("mem_enable", mem_enable, m_fly);
        chk("arb_busy", arb_busy, m_fly);
        chk("owner", owner, m_owner);
        chk("timeout_err", timeout_err, m_terr);
        if (m_fly && !m_rw) chk("mem_data_in", mem_data_in, m_wdata);
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_ack(input bit is_dm, input int maxc, output int lat);
        lat = 0;
        forever begin
            step();
            lat++;
            if ((is_dm ? dm_ack : if_ack) === 1'b1) break;
            if (lat >= maxc) begin
                chk("ack_wait_bound", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        step(); step();
        reset_n = 1;
    endtask

    int lat;
    logic [3:0] seq;
    int nack, last_t, gap;

    initial begin
        step(); step();
        chk("rst_enable", mem_enable, 0);
        chk("rst_rw", mem_read_write, 0);
        chk("rst_busy", arb_busy, 0);
        reset_n = 1;
        step();

        // IF read
        if_req = 1; if_addr = 32'h8002_0000; mem_data_out = 32'h2408_000A;
        step();
        chk("t1_rw", mem_read_write, 1);
        chk("t1_addr", mem_address, 32'h8002_0000);
        step(); step();
        chk("t1_ack", if_ack, 1);
        chk("t1_rdata", if_rdata, 32'h2408_000A);
        if_req = 0;

        // DM store, issued in the IF ack cycle
        dm_req = 1; dm_we = 1; dm_addr = 32'h8002_0100; dm_wdata = 32'h1234_5678;
        mem_data_out = 32'hFFFF_0000;
        step();
        chk("t2_rw", mem_read_write, 0);
        chk("t2_wdata", mem_data_in, 32'h1234_5678);
        step(); step();
        chk("t2_ack", dm_ack, 1);
        chk("t2_rdata", dm_rdata, 32'h0);
        dm_req = 0; dm_we = 0;
        step();

        // DM load with busy held for 5 WAIT cycles
        dm_req = 1; dm_addr = 32'h8002_0200; mem_busy = 1; mem_data_out = 32'hDEAD_0001;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (dm_ack === 1'b1) begin lat = i; break; end
            chk("t4_enable", mem_enable, 1);
            if (i == 3) mem_data_out = 32'hDEAD_0003;
            if (i == 7) begin mem_busy = 0; mem_data_out = 32'h5A5A_0004; end
        end
        chk("t4_latency", lat, 8);
        chk("t4_rdata", dm_rdata, 32'h5A5A_0004);
        dm_req = 0;
        step();

        // Contention from reset: DM, IF, DM, IF
        do_reset();
        if_req = 1; if_addr = 32'h100; dm_req = 1; dm_addr = 32'h200; mem_data_out = 32'hCAFE_0000;
        nack = 0; seq = 0; last_t = 0;
        for (int i = 1; i <= 20 && nack < 4; i++) begin
            step();
            if (if_ack || dm_ack) begin
                seq[nack] = dm_ack;
                if (nack > 0) begin gap = i - last_t; chk("t3_gap", gap, 3); end
                last_t = i;
                nack++;
            end
        end
        if_req = 0; dm_req = 0;
        chk("t3_count", nack, 4);
        chk("t3_order", seq, 4'b0101);
        step();

        // Reset during WAIT aborts, then the held IF request is re-granted
        if_req = 1; if_addr = 32'h8000_0040; mem_busy = 1;
        step(); step();
        chk("t5_inwait", arb_busy, 1);
        reset_n = 0;
        #1;
        chk("t5_enable", mem_enable, 0);
        chk("t5_busy", arb_busy, 0);
        chk("t5_addr", mem_address, 0);
        chk("t5_rdata", if_rdata, 0);
        chk("t5_ack", if_ack, 0);
        step();
        reset_n = 1; mem_busy = 0; mem_data_out = 32'h0BAD_F00D;
        wait_ack(1'b0, 10, lat);
        chk("t5_latency", lat, 3);
        chk("t5_rdata2", if_rdata, 32'h0BAD_F00D);
        if_req = 0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        dm_req = 1; dm_we = 0; dm_addr = 32'h4; mem_busy = 1; mem_data_out = 32'h1111_1111;
        wait_ack(1'b1, 20, lat);
        chk("t6_latency", lat, 6);
        chk("t6_rdata", dm_rdata, 32'h0);
        chk("t6_err", timeout_err, 1);
        dm_req = 0; mem_busy = 0;
        step(); step(); step();
        chk("t6_sticky", timeout_err, 1);
        do_reset();
        chk("t6_cleared", timeout_err, 0);
`else
        dm_req = 1; dm_we = 0; dm_addr = 32'h4; mem_busy = 1;
        repeat (10) step();
        chk("t6_noabort", arb_busy, 1);
        chk("t6_noerr", timeout_err, 0);
        mem_busy = 0;
        wait_ack(1'b1, 5, lat);
        dm_req = 0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
